// File: rtl/joybus_pkg.sv
// joybus_pkg: command encodings, per-command transfer lengths and the
// scheduler state type shared by the JOYBUS command scheduler files.
package joybus_pkg;

    localparam logic [7:0] JB_OP_STATUS = 8'h00;
    localparam logic [7:0] JB_OP_ORIGIN = 8'h41;
    localparam logic [7:0] JB_OP_POLL   = 8'h40;
    localparam logic [7:0] JB_OP_RESET  = 8'hFF;

    localparam logic [1:0] JB_TX_LEN_SHORT = 2'd1;
    localparam logic [1:0] JB_TX_LEN_POLL  = 2'd3;

    localparam logic [3:0] JB_RX_LEN_RESET  = 4'd3;
    localparam logic [3:0] JB_RX_LEN_ORIGIN = 4'd10;
    localparam logic [3:0] JB_RX_LEN_STATUS = 4'd3;
    localparam logic [3:0] JB_RX_LEN_POLL   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_TX,
        ST_WAIT_RX,
        ST_GAP
    } jb_state_t;

    function automatic logic [1:0] jb_tx_len(input logic [7:0] op);
        return (op == JB_OP_POLL) ? JB_TX_LEN_POLL : JB_TX_LEN_SHORT;
    endfunction

    function automatic logic [3:0] jb_rx_len(input logic [7:0] op);
        case (op)
            JB_OP_RESET:  return JB_RX_LEN_RESET;
            JB_OP_ORIGIN: return JB_RX_LEN_ORIGIN;
            JB_OP_POLL:   return JB_RX_LEN_POLL;
            default:      return JB_RX_LEN_STATUS;
        endcase
    endfunction

endpackage

// File: rtl/joybus_req_latch.sv
// joybus_req_latch: rising-edge detection of the button requests, sticky
// pending flags and the fixed-priority selector (reset > origin > status > poll).
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_reset/origin/status       raw request levels
//   poll_set                      one-cycle pulse from the poll timer
//   clr                           one-hot pending bits to clear (accepted command)
//   pending                       {reset, origin, status, poll}
//   grant, grant_op               one-hot winner and its command byte
module joybus_req_latch
    import joybus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_reset,
    input  logic       req_origin,
    input  logic       req_status,
    input  logic       poll_set,
    input  logic [3:0] clr,
    output logic [3:0] pending,
    output logic [3:0] grant,
    output logic [7:0] grant_op
);

    logic       armed;
    logic [2:0] req_q;
    logic [2:0] req_now;
    logic [2:0] rise;

    assign req_now = {req_reset, req_origin, req_status};
    // armed stays low for the first cycle after reset so a level already
    // high at release is absorbed into req_q instead of looking like an edge.
    assign rise    = armed ? (req_now & ~req_q) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            req_q   <= 3'b000;
            pending <= 4'b0000;
        end else begin
            armed   <= 1'b1;
            req_q   <= req_now;
            // set after clear: a fresh edge in the accept cycle survives
            pending <= (pending & ~clr) | {rise, poll_set};
        end
    end

    always_comb begin
        grant    = 4'b0000;
        grant_op = JB_OP_STATUS;
        if (pending[3]) begin
            grant    = 4'b1000;
            grant_op = JB_OP_RESET;
        end else if (pending[2]) begin
            grant    = 4'b0100;
            grant_op = JB_OP_ORIGIN;
        end else if (pending[1]) begin
            grant    = 4'b0010;
            grant_op = JB_OP_STATUS;
        end else if (pending[0]) begin
            grant    = 4'b0001;
            grant_op = JB_OP_POLL;
        end
    end

endmodule

// File: rtl/joybus_cmd_scheduler.sv
// joybus_cmd_scheduler: picks the next JOYBUS command (periodic POLL or a
// latched RESET/ORIGIN/STATUS request), offers it to the transceiver, tracks
// TX/RX completion or response timeout, then enforces an idle bus gap.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_reset/origin/status       button requests (rising edge latched)
//   poll_en                       enable periodic POLL
//   cmd_valid/ready, cmd_op/arg/tx_len/rx_len   command handshake to transceiver
//   tx_done, rx_done, rx_err      transceiver event pulses
//   busy, pending                 status
//   rsp_ok, rsp_fail, rsp_op, timeout_cnt       completion reporting
module joybus_cmd_scheduler
    import joybus_pkg::*;
#(
    parameter int          POLL_PERIOD = 400000,
    parameter int          RSP_TIMEOUT = 10000,
    parameter int          GAP_CYCLES  = 2500,
    parameter logic [15:0] POLL_ARG    = 16'h0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_reset,
    input  logic        req_origin,
    input  logic        req_status,
    input  logic        poll_en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_arg,
    output logic [1:0]  cmd_tx_len,
    output logic [3:0]  cmd_rx_len,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic        busy,
    output logic [3:0]  pending,
    output logic        rsp_ok,
    output logic        rsp_fail,
    output logic [7:0]  rsp_op,
    output logic [7:0]  timeout_cnt
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(((RSP_TIMEOUT > GAP_CYCLES) ? RSP_TIMEOUT : GAP_CYCLES) + 1);

    jb_state_t   state;
    logic [PW-1:0] poll_cnt;
    logic        poll_wrap;
    logic [TW-1:0] timer;
    logic [3:0]  grant;
    logic [3:0]  grant_q;
    logic [7:0]  grant_op;
    logic [3:0]  clr;
    logic        rx_timeout;
    logic        rx_finish;
    logic        rx_good;

    assign poll_wrap  = (poll_cnt == PW'(POLL_PERIOD - 1));
    assign clr        = (cmd_valid && cmd_ready) ? grant_q : 4'b0000;
    assign busy       = (state != ST_IDLE);
    assign rx_timeout = (timer == TW'(RSP_TIMEOUT - 1));
    assign rx_finish  = rx_err || rx_done || rx_timeout;
    // rx_err beats rx_done; rx_done beats a simultaneous timeout
    assign rx_good    = rx_done && !rx_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
        end
    end

    joybus_req_latch u_req_latch (
        .clk        (clk),
        .rst        (rst),
        .req_reset  (req_reset),
        .req_origin (req_origin),
        .req_status (req_status),
        .poll_set   (poll_wrap && poll_en),
        .clr        (clr),
        .pending    (pending),
        .grant      (grant),
        .grant_op   (grant_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_valid   <= 1'b0;
            cmd_op      <= 8'h00;
            cmd_arg     <= 16'h0000;
            cmd_tx_len  <= 2'd0;
            cmd_rx_len  <= 4'd0;
            grant_q     <= 4'b0000;
            timer       <= '0;
            rsp_ok      <= 1'b0;
            rsp_fail    <= 1'b0;
            rsp_op      <= 8'h00;
            timeout_cnt <= 8'h00;
        end else begin
            rsp_ok   <= 1'b0;
            rsp_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        cmd_valid  <= 1'b1;
                        cmd_op     <= grant_op;
                        cmd_arg    <= (grant_op == JB_OP_POLL) ? POLL_ARG : 16'h0000;
                        cmd_tx_len <= jb_tx_len(grant_op);
                        cmd_rx_len <= jb_rx_len(grant_op);
                        grant_q    <= grant;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        timer <= '0;
                        state <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (rx_finish) begin
                        rsp_ok   <= rx_good;
                        rsp_fail <= !rx_good;
                        rsp_op   <= cmd_op;
                        if (!rx_good && timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                        timer <= '0;
                        state <= ST_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_cmd_scheduler.sv
module tb_joybus_cmd_scheduler;

    localparam int          POLL_PERIOD = 1000;
    localparam int          RSP_TIMEOUT = 200;
    localparam int          GAP_CYCLES  = 50;
    localparam logic [15:0] POLL_ARG    = 16'h0300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_reset = 1'b0;
    logic        req_origin = 1'b0;
    logic        req_status = 1'b0;
    logic        poll_en = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic [1:0]  cmd_tx_len;
    logic [3:0]  cmd_rx_len;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic        rx_err = 1'b0;
    logic        busy;
    logic [3:0]  pending;
    logic        rsp_ok;
    logic        rsp_fail;
    logic [7:0]  rsp_op;
    logic [7:0]  timeout_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_tcnt = 0;
    logic [29:0] sb[$];
    logic [29:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    joybus_cmd_scheduler #(
        .POLL_PERIOD (POLL_PERIOD),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .GAP_CYCLES  (GAP_CYCLES),
        .POLL_ARG    (POLL_ARG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_reset   (req_reset),
        .req_origin  (req_origin),
        .req_status  (req_status),
        .poll_en     (poll_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cmd_tx_len  (cmd_tx_len),
        .cmd_rx_len  (cmd_rx_len),
        .tx_done     (tx_done),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .busy        (busy),
        .pending     (pending),
        .rsp_ok      (rsp_ok),
        .rsp_fail    (rsp_fail),
        .rsp_op      (rsp_op),
        .timeout_cnt (timeout_cnt)
    );

    // expected {op, arg, tx_len, rx_len} from the command table
    function automatic logic [29:0] exp_cmd(input logic [7:0] op);
        case (op)
            8'hFF:   return {8'hFF, 16'h0000, 2'd1, 4'd3};
            8'h41:   return {8'h41, 16'h0000, 2'd1, 4'd10};
            8'h40:   return {8'h40, POLL_ARG, 2'd3, 4'd8};
            default: return {8'h00, 16'h0000, 2'd1, 4'd3};
        endcase
    endfunction

    // scoreboard: every accepted command is matched against the next expected one
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got op=%02h, none expected", cmd_op);
            end else begin
                mon_exp = sb.pop_front();
                if ({cmd_op, cmd_arg, cmd_tx_len, cmd_rx_len} !== mon_exp) begin
                    errors++;
                    $display("FAIL issue_fields got=%08h expected=%08h",
                             {cmd_op, cmd_arg, cmd_tx_len, cmd_rx_len}, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_status();
        req_status = 1'b1;
        tick();
        req_status = 1'b0;
    endtask

    // transceiver model: accept, finish TX, then respond according to mode
    // mode 0: rx_done after delay, 1: no response, 2: rx_err,
    // 3: rx_done on the timeout cycle, 4: rx_err together with rx_done
    task automatic serve(input int mode, input int delay, output bit no_cmd,
                         output logic ok_o, output logic fail_o, output logic early_o,
                         output logic [7:0] op_o, output int issue_c, output int done_c);
        int n;
        n = 0; no_cmd = 0; ok_o = 0; fail_o = 0; early_o = 0; op_o = 0;
        issue_c = 0; done_c = 0;
        while (cmd_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (cmd_valid !== 1'b1) begin
            no_cmd = 1;
            return;
        end
        issue_c = cyc;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        case (mode)
            0: begin
                repeat (delay - 1) tick();
                rx_done = 1'b1; tick(); rx_done = 1'b0;
            end
            1: begin
                repeat (RSP_TIMEOUT - 1) tick();
                early_o = rsp_ok | rsp_fail;
                tick();
            end
            2: begin
                rx_err = 1'b1; tick(); rx_err = 1'b0;
            end
            3: begin
                repeat (RSP_TIMEOUT - 1) tick();
                early_o = rsp_ok | rsp_fail;
                rx_done = 1'b1; tick(); rx_done = 1'b0;
            end
            default: begin
                rx_err = 1'b1; rx_done = 1'b1; tick();
                rx_err = 1'b0; rx_done = 1'b0;
            end
        endcase
        ok_o = rsp_ok;
        fail_o = rsp_fail;
        op_o = rsp_op;
        done_c = cyc;
    endtask

    task automatic test_reset();
        int seen;
        req_status = 1'b1;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({cmd_valid, busy, pending, rsp_ok, rsp_fail, rsp_op, timeout_cnt,
             cmd_op, cmd_arg, cmd_tx_len, cmd_rx_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b pend=%h op=%h cnt=%h, all required 0",
                     cmd_valid, busy, pending, cmd_op, timeout_cnt);
        end
        tick(); tick();
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (cmd_valid || busy || pending != 0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_held_level got %0d active cycles, required 0", seen);
        end
        req_status = 1'b0;
        tick();
    endtask

    task automatic test_spurious();
        int seen;
        seen = 0;
        tx_done = 1'b1; rx_done = 1'b1; rx_err = 1'b1;
        repeat (3) begin
            tick();
            if (rsp_ok || rsp_fail || busy) seen++;
        end
        tx_done = 1'b0; rx_done = 1'b0; rx_err = 1'b0;
        tick();
        if (rsp_ok || rsp_fail || busy || timeout_cnt != 0) seen++;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL spurious_pulses got %0d reactions, required 0", seen);
        end
    endtask

    task automatic test_origin();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc, seen;
        sb.push_back(exp_cmd(8'h41));
        req_origin = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL origin_latency1 got valid=%b required 0", cmd_valid);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++; $display("FAIL origin_latency2 got valid=%b required 1", cmd_valid);
        end
        fork
            begin repeat (6) tick(); req_origin = 1'b0; end
        join_none
        serve(0, 30, nc, ok, fl, ea, op, ic, dc);
        checks++;
        if (nc || ok !== 1'b1 || fl !== 1'b0 || op !== 8'h41) begin
            errors++;
            $display("FAIL origin_rsp got nocmd=%0b ok=%b fail=%b op=%h required ok=1 fail=0 op=41",
                     nc, ok, fl, op);
        end
        repeat (49) tick();
        checks++;
        if (busy !== 1'b1 || rsp_ok !== 1'b0) begin
            errors++; $display("FAIL origin_gap49 got busy=%b ok=%b required busy=1 ok=0", busy, rsp_ok);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL origin_gap50 got busy=%b required 0", busy);
        end
        seen = 0;
        repeat (100) begin
            tick();
            if (cmd_valid) seen++;
        end
        checks++;
        if (seen != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL origin_single got extra=%0d queued=%0d required 0 and 0", seen, sb.size());
        end
    endtask

    task automatic test_poll();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc, prev, oks;
        oks = 0; prev = 0;
        poll_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(exp_cmd(8'h40));
            serve(0, 30, nc, ok, fl, ea, op, ic, dc);
            if (!nc && ok === 1'b1 && op === 8'h40) oks++;
            if (k > 0) begin
                checks++;
                if (nc || ic - prev != POLL_PERIOD) begin
                    errors++;
                    $display("FAIL poll_period got %0d cycles required %0d", ic - prev, POLL_PERIOD);
                end
            end
            prev = ic;
        end
        poll_en = 1'b0;
        checks++;
        if (oks != 5) begin
            errors++; $display("FAIL poll_ok_count got %0d required 5", oks);
        end
    endtask

    task automatic test_priority();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc, prev_done, seen;
        logic [7:0] order [3];
        order[0] = 8'hFF; order[1] = 8'h41; order[2] = 8'h00;
        for (int k = 0; k < 3; k++) sb.push_back(exp_cmd(order[k]));
        req_reset = 1'b1; req_origin = 1'b1; req_status = 1'b1;
        tick();
        req_reset = 1'b0; req_origin = 1'b0; req_status = 1'b0;
        // a repeated status edge while status is still pending must merge
        fork
            begin repeat (10) tick(); req_status = 1'b1; tick(); req_status = 1'b0; end
        join_none
        prev_done = 0;
        for (int k = 0; k < 3; k++) begin
            serve(0, 5, nc, ok, fl, ea, op, ic, dc);
            checks++;
            if (nc || ok !== 1'b1 || op !== order[k]) begin
                errors++;
                $display("FAIL priority_order[%0d] got nocmd=%0b ok=%b op=%h required op=%h",
                         k, nc, ok, op, order[k]);
            end
            if (k > 0) begin
                checks++;
                if (ic - prev_done < GAP_CYCLES) begin
                    errors++;
                    $display("FAIL priority_gap[%0d] got %0d cycles required >= %0d",
                             k, ic - prev_done, GAP_CYCLES);
                end
            end
            prev_done = dc;
        end
        seen = 0;
        repeat (200) begin
            tick();
            if (cmd_valid) seen++;
        end
        checks++;
        if (seen != 0 || sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL priority_merge got extra=%0d queued=%0d busy=%b required 0 0 0",
                     seen, sb.size(), busy);
        end
    endtask

    task automatic test_rx_race();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc;
        sb.push_back(exp_cmd(8'h00));
        pulse_status();
        serve(3, 0, nc, ok, fl, ea, op, ic, dc);
        checks++;
        if (nc || ea !== 1'b0 || ok !== 1'b1 || fl !== 1'b0) begin
            errors++;
            $display("FAIL race_done_vs_timeout got early=%b ok=%b fail=%b required 0 1 0", ea, ok, fl);
        end
        checks++;
        if (timeout_cnt !== 8'(exp_tcnt)) begin
            errors++;
            $display("FAIL race_cnt_unchanged got %0d required %0d", timeout_cnt, exp_tcnt);
        end
        repeat (60) tick();
        sb.push_back(exp_cmd(8'h00));
        pulse_status();
        serve(4, 0, nc, ok, fl, ea, op, ic, dc);
        if (exp_tcnt < 255) exp_tcnt++;
        checks++;
        if (nc || ok !== 1'b0 || fl !== 1'b1 || timeout_cnt !== 8'(exp_tcnt)) begin
            errors++;
            $display("FAIL race_err_vs_done got ok=%b fail=%b cnt=%0d required 0 1 %0d",
                     ok, fl, timeout_cnt, exp_tcnt);
        end
    endtask

    task automatic test_timeout();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc, fails;
        repeat (60) tick();
        sb.push_back(exp_cmd(8'h00));
        pulse_status();
        serve(1, 0, nc, ok, fl, ea, op, ic, dc);
        if (exp_tcnt < 255) exp_tcnt++;
        checks++;
        if (nc || ea !== 1'b0 || fl !== 1'b1 || ok !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exact got early=%b fail=%b ok=%b required 0 1 0", ea, fl, ok);
        end
        checks++;
        if (timeout_cnt !== 8'(exp_tcnt) || rsp_op !== 8'h00) begin
            errors++;
            $display("FAIL timeout_count got cnt=%0d op=%h required %0d op=00",
                     timeout_cnt, rsp_op, exp_tcnt);
        end
        fails = 0;
        for (int k = 0; k < 300; k++) begin
            repeat (55) tick();
            sb.push_back(exp_cmd(8'h00));
            pulse_status();
            serve(2, 0, nc, ok, fl, ea, op, ic, dc);
            if (exp_tcnt < 255) exp_tcnt++;
            if (!nc && fl === 1'b1) fails++;
        end
        checks++;
        if (fails != 300) begin
            errors++; $display("FAIL rx_err_fails got %0d required 300", fails);
        end
        checks++;
        if (timeout_cnt !== 8'(exp_tcnt) || timeout_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_saturate got %0d required 255", timeout_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit nc; logic ok, fl, ea; logic [7:0] op; int ic, dc, n, seen;
        repeat (60) tick();
        sb.push_back(exp_cmd(8'h41));
        req_origin = 1'b1; tick(); req_origin = 1'b0;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_issue got valid=%b required 1", cmd_valid);
        end
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        req_status = 1'b1;
        tick();
        checks++;
        if (pending[1] !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got pend=%h busy=%b required status set, busy 1", pending, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || pending !== 4'h0) begin
            errors++;
            $display("FAIL midrst_async got valid=%b busy=%b pend=%h required 0 0 0",
                     cmd_valid, busy, pending);
        end
        tick(); tick();
        rst = 1'b0;
        exp_tcnt = 0;
        seen = 0;
        repeat (300) begin
            tick();
            if (cmd_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midrst_quiet got %0d active cycles required 0", seen);
        end
        req_status = 1'b0;
        tick();
        sb.push_back(exp_cmd(8'h00));
        pulse_status();
        serve(0, 5, nc, ok, fl, ea, op, ic, dc);
        checks++;
        if (nc || ok !== 1'b1 || op !== 8'h00) begin
            errors++;
            $display("FAIL midrst_new_edge got nocmd=%0b ok=%b op=%h required ok=1 op=00", nc, ok, op);
        end
    endtask

    initial begin
        test_reset();
        test_spurious();
        test_origin();
        test_poll();
        test_priority();
        test_rx_race();
        test_timeout();
        test_reset_mid();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joybus_cmd_scheduler.md
Name: joybus_cmd_scheduler

Overview:
- Sequences the JOYBUS host transceiver: decides which controller command goes on the wire next and hands it to the transceiver one at a time.
- Sources: a periodic POLL timer plus three sticky one-shot requests (RESET, ORIGIN, STATUS), typically from debounced board buttons.
- Tracks each transaction through TX completion, RX completion or timeout, then a mandatory bus gap.
- Reports outcome pulses and a saturating timeout count to the debug/LED logic.

Parameters:
- POLL_PERIOD, 400000, cycles between automatic POLL requests (16 ms at 25 MHz)
- RSP_TIMEOUT, 10000, max cycles from tx_done to rx_done before declaring timeout
- GAP_CYCLES, 2500, idle cycles enforced after every transaction before the next issue
- POLL_ARG, 16'h0300, argument bytes sent with POLL (0x40)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_reset  in  1  request RESET command 0xFF; rising edge latched
- req_origin  in  1  request ORIGIN command 0x41; rising edge latched
- req_status  in  1  request STATUS command 0x00; rising edge latched
- poll_en  in  1  enables the periodic POLL source
- cmd_valid  out  1  command offered to transceiver
- cmd_ready  in  1  transceiver accepts command
- cmd_op  out  8  command byte
- cmd_arg  out  16  argument bytes (POLL only, else 0)
- cmd_tx_len  out  2  bytes to transmit: 1 or 3
- cmd_rx_len  out  4  expected response bytes
- tx_done  in  1  one-cycle pulse: transmit finished
- rx_done  in  1  one-cycle pulse: response received
- rx_err  in  1  one-cycle pulse: malformed response
- busy  out  1  high in any state except IDLE
- pending  out  4  {reset, origin, status, poll} pending flags
- rsp_ok  out  1  one-cycle pulse: transaction completed OK
- rsp_fail  out  1  one-cycle pulse: timeout or rx_err
- rsp_op  out  8  op of the last completed transaction; held until the next completion
- timeout_cnt  out  8  saturating count of failures

Behaviour:
- Reset state: every output is 0; FSM in IDLE; poll timer at 0; edge-detect registers at 0.
  - An asserted input at reset release is not treated as an edge.
- Requests:
  - Rising edge of req_* sets the matching pending bit.
  - Poll timer counts every cycle in every state and wraps at POLL_PERIOD-1. On wrap, the poll pending bit is set if poll_en is 1.
  - Repeated requests for an already-pending op merge into one.
  - A pending bit clears on the cmd_valid && cmd_ready cycle. A new edge for the same op in that same cycle leaves the bit set.
  - poll_en=0 does not clear an already-set poll pending bit.
- Priority (fixed, evaluated only in IDLE): reset > origin > status > poll.
- Command table (op, tx_len, rx_len, arg):
  - RESET: 0xFF, 1, 3, 0
  - ORIGIN: 0x41, 1, 10, 0
  - STATUS: 0x00, 1, 3, 0
  - POLL: 0x40, 3, 8, POLL_ARG
- FSM:
  - IDLE: if any pending bit is set, register the selected op's fields and go to ISSUE next cycle.
  - ISSUE: cmd_valid=1. cmd_op, cmd_arg and the lengths are stable until accepted. On cmd_ready, go to WAIT_TX.
  - WAIT_TX: on tx_done, clear the timer and go to WAIT_RX.
  - WAIT_RX:
    - Timer increments each cycle.
    - rx_done: rsp_ok pulse, go to GAP.
    - rx_err: rsp_fail pulse, go to GAP.
    - Timer reaches RSP_TIMEOUT-1 with no rx_done/rx_err: rsp_fail pulse, go to GAP.
    - rx_done wins over a timeout in the same cycle. rx_err wins over rx_done in the same cycle.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Outputs on completion:
  - rsp_op is updated in the same cycle as the rsp_ok or rsp_fail pulse.
  - timeout_cnt increments on each rsp_fail and saturates at 255.
- Latency: with cmd_ready tied high, minimum 2 cycles from the request edge to cmd_valid.
- Spurious pulses: tx_done/rx_done/rx_err outside their wait states are ignored.
- Reset mid-operation: immediate return to IDLE, cmd_valid drops asynchronously, all pending bits are lost.

Decomposition:
- Shared package joybus_pkg holds:
  - op constants (JB_OP_STATUS, JB_OP_ORIGIN, JB_OP_POLL, JB_OP_RESET)
  - per-op tx/rx length constants
  - FSM state enum
- Natural sub-module: joybus_req_latch. It does edge detect plus sticky pending bits plus the priority encoder that outputs the one-hot grant and op.

Test Plan (POLL_PERIOD=1000, RSP_TIMEOUT=200, GAP_CYCLES=50, cmd_ready=1):
- req_origin high for 8 cycles, poll_en=0 -> exactly one issue: cmd_op=0x41, tx_len=1, rx_len=10. tx_done then rx_done 30 cycles later -> rsp_ok=1 for 1 cycle, rsp_op=0x41, busy low 50 cycles after rsp_ok.
- poll_en=1, model answers every command -> POLL (0x40, arg 0x0300, tx_len=3, rx_len=8) issued once per 1000 cycles; 5 periods give 5 rsp_ok pulses.
- req_reset, req_status and req_origin edges in the same cycle -> issue order 0xFF, 0x41, 0x00, each separated by a gap of at least 50 cycles.
- tx_done without rx_done -> rsp_fail exactly 200 cycles after tx_done, timeout_cnt=1. After 300 such failures timeout_cnt=255 (saturated).
- rx_done in the same cycle the timer expires -> rsp_ok=1, rsp_fail=0, timeout_cnt unchanged. rx_err together with rx_done -> rsp_fail=1.
- Assert rst during WAIT_RX with status pending -> cmd_valid, busy and pending are 0 immediately. After release, no command is issued until a new edge or poll wrap.
